uart_frame_sched: RTL
=====================

Name: uart_frame_sched

Overview:
- Round-robin scheduler that shares the single correlator UART transmitter among NUM_CH result producers.
- Each granted word goes out as one framed packet: sync byte, channel index, data bytes MSB first, optional checksum.
- Sits between the correlator result registers and the UART byte transmitter, and drives its din/tx_start/tx_done handshake.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- WORD_BYTES, 2, bytes per channel word (1..8).
- SYNC_BYTE, 8'hA5, frame header byte.
- HOLDOFF, 160, cycles after reset before the first grant; must be at least one full UART byte time, (8+2)<<SHIFT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_CH  per-channel request; held high until the matching ack.
- data  in  NUM_CH*WORD_BYTES*8  channel words; channel k at bits [k*WORD_BYTES*8 +: WORD_BYTES*8].
- ack  out  NUM_CH  one-cycle pulse; the channel's word has been captured.
- uart_din  out  8  byte to transmitter; held stable while uart_start is high.
- uart_start  out  1  level "byte pending" to transmitter.
- uart_done  in  1  transmitter stop-bit pulse (one cycle per byte).
- busy  out  1  high from grant until the last byte's uart_done.
- frame_count  out  16  frames completed, wraps at 2^16.

Behaviour:
- Reset values: ack=0, uart_din=8'hFF, uart_start=0, busy=0, frame_count=0, rr pointer=0, holdoff counter=HOLDOFF, state=HOLD.
- States: HOLD, IDLE, SYNC, CHAN, DATA, (CSUM), back to IDLE.
- HOLD: counter decrements each cycle. At 0, go to IDLE. req is ignored and ack stays 0. This lets a byte left in flight by reset drain, so its uart_done is never credited to a new frame.
- IDLE, grant selection:
  - If any req bit is set, grant the first set bit searching ptr, ptr+1, ... mod NUM_CH.
  - On that edge: capture data[g] into the shift register, ack[g]=1 for one cycle, busy=1, chan=g, ptr<=(g+1) mod NUM_CH, uart_din<=SYNC_BYTE, uart_start<=1.
  - Next state is SYNC.
  - Latency: req high at edge N gives ack and uart_start high after edge N.
- Byte advance: in each send state, wait for uart_done. On the uart_done cycle, load the next byte into uart_din and keep uart_start high. The transmitter picks the byte up when it returns idle.
- Byte order:
  - SYNC: next byte is zero-extended chan.
  - CHAN: next byte is the captured word MSB byte.
  - DATA: sends WORD_BYTES bytes, MSB first, counted by a byte counter from WORD_BYTES-1 down to 0.
- Last byte's uart_done: uart_start<=0, uart_din<=8'hFF, busy<=0, frame_count<=frame_count+1, next state IDLE. A new grant can occur on the following edge.
- uart_done outside a send state is ignored.
- req changes while busy have no effect until IDLE. A req dropped before its grant is simply not served.
- Simultaneous requests are resolved only by the rr pointer. A channel re-requesting immediately after its ack is served after all other pending channels.
- Reset mid-frame: immediate return to reset values and HOLD. The partial frame is abandoned and is not counted.

Optional Feature:
- Macro UART_FRAME_CSUM_EN.
- When defined: state CSUM is appended after DATA. The CSUM byte is the XOR of the channel byte and all data bytes. Frame length is WORD_BYTES+3 bytes, and frame_count increments on CSUM's uart_done.
- When undefined: there is no CSUM state and no checksum register. Frame length is WORD_BYTES+2 bytes.

Test Plan:
- Post-reset holdoff: rst pulse with req=4'b0001 held -> ack stays 0 for HOLDOFF cycles; ack[0] pulses on the cycle after the holdoff expires.
- Single frame: NUM_CH=4, WORD_BYTES=2, ch2 word 16'h1234, transmitter model returns uart_done 40 cycles after each byte:
  - CSUM_EN undefined: uart_din sequence A5, 02, 12, 34; frame_count=1; busy falls on the 4th uart_done.
  - CSUM_EN defined: sequence A5, 02, 12, 34, 24; frame_count=1.
- Round-robin fairness: req=4'b1111 held, re-asserted after each ack -> grant order 0, 1, 2, 3, 0; no channel is granted twice in a row.
- Pointer skip: ptr=1 with req=4'b1001 -> ch3 granted first, then ch0.
- Reset mid-frame: rst asserted during the DATA byte -> uart_start=0 and busy=0 immediately; frame_count unchanged; a stray uart_done during HOLD is ignored; the next frame starts with A5.
- frame_count wrap: preload 16'hFFFF via force, complete one frame -> frame_count=0.

Source files
------------

// File: rtl/uart_frame_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_CH result producers.
// Optional checksum byte per frame when UART_FRAME_CSUM_EN is defined.
module uart_frame_sched #(
  parameter int         NUM_CH     = 4,
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         HOLDOFF    = 160
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                req,
  input  logic [NUM_CH*WORD_BYTES*8-1:0]   data,
  output logic [NUM_CH-1:0]                ack,
  output logic [7:0]                       uart_din,
  output logic                             uart_start,
  input  logic                             uart_done,
  output logic                             busy,
  output logic [15:0]                      frame_count
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int HO_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(WORD_BYTES - 1);
  localparam logic [HO_W-1:0]   HO_INIT = HO_W'(HOLDOFF);
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ACK_ONE = NUM_CH'(1);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_IDLE = 3'd1,
    S_SYNC = 3'd2,
    S_CHAN = 3'd3,
    S_DATA = 3'd4
`ifdef UART_FRAME_CSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [HO_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [7:0]        din_q, din_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [15:0]       fcnt_q, fcnt_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [CH_W-1:0]   gnt_s;
  logic [CH_W-1:0]   idx_s;
  logic              found_s;
  logic [WORD_W-1:0] word_s;
  logic              fin_s;

`ifdef UART_FRAME_CSUM_EN
  function automatic logic [7:0] frame_csum(input logic [CH_W-1:0] ch,
                                            input logic [WORD_W-1:0] w);
    logic [7:0] acc;
    acc = 8'(ch);
    for (int b = 0; b < WORD_BYTES; b++) begin
      acc = acc ^ w[b*8 +: 8];
    end
    return acc;
  endfunction
`endif

  // Grant search from ptr upward (lowest offset wins) and word select for the winner.
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    word_s  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx_s   = CH_W'((int'(ptr_q) + i) % NUM_CH);
      gnt_s   = req[idx_s] ? idx_s : gnt_s;
      found_s = found_s | req[idx_s];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      word_s = (gnt_s == CH_W'(k)) ? data[k*WORD_W +: WORD_W] : word_s;
    end
  end

  // Frame sequencing: next state, next byte and handshake outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    chan_d  = chan_q;
    bcnt_d  = bcnt_q;
    din_d   = din_q;
    start_d = start_q;
    busy_d  = busy_q;
    ack_d   = '0;
    fcnt_d  = fcnt_q;
    fin_s   = 1'b0;
`ifdef UART_FRAME_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - HO_W'(1);
        end
      end
      S_IDLE: begin
        if (found_s) begin
          shift_d = word_s;
          chan_d  = gnt_s;
          ack_d   = ACK_ONE << gnt_s;
          busy_d  = 1'b1;
          ptr_d   = (gnt_s == CH_LAST) ? '0 : gnt_s + CH_W'(1);
          din_d   = SYNC_BYTE;
          start_d = 1'b1;
          state_d = S_SYNC;
`ifdef UART_FRAME_CSUM_EN
          csum_d  = frame_csum(gnt_s, word_s);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (uart_done) begin
          din_d   = 8'(chan_q);
          state_d = S_CHAN;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_CHAN: begin
        if (uart_done) begin
          din_d   = shift_q[WORD_W-1 -: 8];
          shift_d = shift_q << 4'd8;
          bcnt_d  = BC_LAST;
          state_d = S_DATA;
        end else begin
          state_d = S_CHAN;
        end
      end
      S_DATA: begin
        // bcnt counts the data bytes still to follow the one on the wire
        if (uart_done && (bcnt_q != '0)) begin
          din_d   = shift_q[WORD_W-1 -: 8];
          shift_d = shift_q << 4'd8;
          bcnt_d  = bcnt_q - BC_W'(1);
        end else if (uart_done) begin
`ifdef UART_FRAME_CSUM_EN
          din_d   = csum_q;
          state_d = S_CSUM;
`else
          fin_s   = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_FRAME_CSUM_EN
      S_CSUM: begin
        if (uart_done) begin
          fin_s = 1'b1;
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      default: begin
        state_d = S_HOLD;
        hold_d  = HO_INIT;
        din_d   = 8'hFF;
        start_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    if (fin_s) begin
      din_d   = 8'hFF;
      start_d = 1'b0;
      busy_d  = 1'b0;
      fcnt_d  = fcnt_q + 16'd1;
      state_d = S_IDLE;
    end else begin
      fcnt_d  = fcnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HOLD;
      ptr_q   <= '0;
      hold_q  <= HO_INIT;
      shift_q <= '0;
      chan_q  <= '0;
      bcnt_q  <= '0;
      din_q   <= 8'hFF;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      fcnt_q  <= 16'd0;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      chan_q  <= chan_d;
      bcnt_q  <= bcnt_d;
      din_q   <= din_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      fcnt_q  <= fcnt_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign ack         = ack_q;
  assign uart_din    = din_q;
  assign uart_start  = start_q;
  assign busy        = busy_q;
  assign frame_count = fcnt_q;

endmodule
